seq_alu: RTL and testbench

- Parametrised, multi-cycle successor to the 16-bit combinational ALU.
- Adds valid/ready handshakes on both sides, a status-flag output, a widened opcode space, and an iterative shift-add multiplier.
- An optional iterative restoring divider can be compiled in.
- Sits between the register-file read stage and writeback; accepts one operation at a time.

---
 rtl/seq_alu_pkg.sv | 31 +++
 rtl/seq_alu_comb.sv | 75 +++++++
 rtl/seq_alu.sv | 218 +++++++++++++++++++++
 tb/tb_seq_alu.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Shared opcode, FSM-state and flag-index definitions for the sequential ALU.
package seq_alu_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,
    OP_OR   = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLT  = 4'd5,
    OP_SHL  = 4'd6,
    OP_SHR  = 4'd7,
    OP_SRA  = 4'd8,
    OP_MUL  = 4'd9,
    OP_DIVU = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  localparam int FLAG_Z    = 0;
  localparam int FLAG_N    = 1;
  localparam int FLAG_C    = 2;
  localparam int FLAG_V    = 3;
  localparam int FLAG_ILL  = 4;
  localparam int NUM_FLAGS = 5;

endpackage

// File: rtl/seq_alu_comb.sv
// Single-cycle ALU operations with carry/overflow/illegal generation.
// Anything it does not recognise (MUL, DIVU, 11..) is reported illegal; the top overrides iterative ops.
module seq_alu_comb
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OPW   = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OPW-1:0]   op,
  output logic [WIDTH-1:0] res,
  output logic             c,
  output logic             v,
  output logic             ill
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0]          sh;
  logic [WIDTH:0]          add_ext;
  logic [WIDTH:0]          sub_ext;
  logic [WIDTH:0]          shl_ext;
  logic [WIDTH:0]          shr_ext;
  logic signed [WIDTH:0]   sra_ext;
  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;

  assign sh      = b[SHW-1:0];
  assign a_s     = a;
  assign b_s     = b;
  assign add_ext = {1'b0, a} + {1'b0, b};
  assign sub_ext = {1'b0, a} - {1'b0, b};
  // Extra guard bit on each shifter catches the last bit shifted out.
  assign shl_ext = {1'b0, a} << sh;
  assign shr_ext = {a, 1'b0} >> sh;
  assign sra_ext = $signed({a, 1'b0}) >>> sh;

  always_comb begin
    res = '0;
    c   = 1'b0;
    v   = 1'b0;
    ill = 1'b0;
    case (op)
      OPW'(OP_AND): res = a & b;
      OPW'(OP_OR):  res = a | b;
      OPW'(OP_XOR): res = a ^ b;
      OPW'(OP_ADD): begin
        res = add_ext[WIDTH-1:0];
        c   = add_ext[WIDTH];
        v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OPW'(OP_SUB): begin
        res = sub_ext[WIDTH-1:0];
        c   = sub_ext[WIDTH];
        v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OPW'(OP_SLT): res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      OPW'(OP_SHL): begin
        res = shl_ext[WIDTH-1:0];
        c   = shl_ext[WIDTH];
      end
      OPW'(OP_SHR): begin
        res = shr_ext[WIDTH:1];
        c   = shr_ext[0];
      end
      OPW'(OP_SRA): begin
        res = sra_ext[WIDTH:1];
        c   = sra_ext[0];
      end
      default: ill = 1'b1;
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready on both sides, shift-add MUL and optional restoring DIVU.
// Define SEQ_ALU_DIV_EN to build the divider; otherwise op 10 is treated as illegal.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int  WIDTH = 16,
  parameter int  OPW   = 4,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OPW-1:0]   op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] res_hi,
  output logic [4:0]       flags
);

  alu_state_e state_q, state_d;
  logic [SHW:0]           cnt_q, cnt_d;
  logic                   out_valid_q, out_valid_d;
  logic [WIDTH-1:0]       res_q, res_d;
  logic [WIDTH-1:0]       res_hi_q, res_hi_d;
  logic [NUM_FLAGS-1:0]   flags_q, flags_d;

  logic [WIDTH-1:0]       a_q, a_d;
  logic [WIDTH-1:0]       b_q, b_d;
  logic [OPW-1:0]         op_q, op_d;
  logic [WIDTH-1:0]       hi_q, hi_d;
  logic [WIDTH-1:0]       lo_q, lo_d;

  logic [WIDTH-1:0]       comb_res;
  logic                   comb_c;
  logic                   comb_v;
  logic                   comb_ill;

  logic                   in_is_mul;
  logic                   in_is_div;
  logic                   q_is_mul;
  logic                   q_is_div;
  logic [WIDTH:0]         mul_sum;
  logic [WIDTH-1:0]       step_hi;
  logic [WIDTH-1:0]       step_lo;

  logic [WIDTH-1:0]       fin_res;
  logic [WIDTH-1:0]       fin_hi;
  logic                   fin_c;
  logic                   fin_v;
  logic                   fin_ill;
  logic [NUM_FLAGS-1:0]   fin_flags;

  seq_alu_comb #(
    .WIDTH (WIDTH),
    .OPW   (OPW)
  ) u_comb (
    .a   (a_q),
    .b   (b_q),
    .op  (op_q),
    .res (comb_res),
    .c   (comb_c),
    .v   (comb_v),
    .ill (comb_ill)
  );

  assign in_is_mul = (op == OPW'(OP_MUL));
  assign q_is_mul  = (op_q == OPW'(OP_MUL));

  // Multiply: hi:lo holds partial product over the not-yet-consumed multiplier bits.
  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});

`ifdef SEQ_ALU_DIV_EN
  logic [WIDTH:0] div_rem;
  logic [WIDTH:0] div_sub;
  logic           div_ge;

  assign in_is_div = (op == OPW'(OP_DIVU));
  assign q_is_div  = (op_q == OPW'(OP_DIVU));
  // Restoring divide: hi is the partial remainder, lo shifts dividend out and quotient in.
  // A zero divisor always subtracts, giving all-ones quotient and remainder = a.
  assign div_rem   = {hi_q, lo_q[WIDTH-1]};
  assign div_sub   = div_rem - {1'b0, b_q};
  assign div_ge    = (div_rem >= {1'b0, b_q});

  always_comb begin
    if (q_is_div) begin
      step_hi = div_ge ? div_sub[WIDTH-1:0] : div_rem[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end
`else
  assign in_is_div = 1'b0;
  assign q_is_div  = 1'b0;

  always_comb begin
    step_hi = mul_sum[WIDTH:1];
    step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
  end
`endif

  always_comb begin
    fin_res = comb_res;
    fin_hi  = '0;
    fin_c   = comb_c;
    fin_v   = comb_v;
    fin_ill = comb_ill;
    if (q_is_mul) begin
      fin_res = lo_q;
      fin_hi  = hi_q;
      fin_c   = 1'b0;
      fin_v   = (hi_q != '0);
      fin_ill = 1'b0;
    end else if (q_is_div) begin
      fin_res = lo_q;
      fin_hi  = hi_q;
      fin_c   = 1'b0;
      fin_v   = (b_q == '0);
      fin_ill = 1'b0;
    end
    fin_flags           = '0;
    fin_flags[FLAG_Z]   = (fin_res == '0);
    fin_flags[FLAG_N]   = fin_res[WIDTH-1];
    fin_flags[FLAG_C]   = fin_c;
    fin_flags[FLAG_V]   = fin_v;
    fin_flags[FLAG_ILL] = fin_ill;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    res_hi_d    = res_hi_q;
    flags_d     = flags_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          cnt_d   = '0;
          hi_d    = '0;
          lo_d    = in_is_mul ? b : a;
          state_d = (in_is_mul || in_is_div) ? BUSY : DONE;
        end
      end
      BUSY: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + (SHW+1)'(1);
        if (cnt_q == (SHW+1)'(WIDTH-1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // First DONE cycle registers the result; afterwards it is held until taken.
        if (!out_valid_q) begin
          res_d       = fin_res;
          res_hi_d    = fin_hi;
          flags_d     = fin_flags;
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      res_hi_q    <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      res_hi_q    <= res_hi_d;
      flags_q     <= flags_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q  <= a_d;
    b_q  <= b_d;
    op_q <= op_d;
    hi_q <= hi_d;
    lo_q <= lo_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign res       = res_q;
  assign res_hi    = res_hi_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed and pseudo-random scoreboard bench for seq_alu at WIDTH=16.
module tb_seq_alu;
  import seq_alu_pkg::*;

  typedef struct {
    logic [15:0] res;
    logic [15:0] hi;
    logic [4:0]  flags;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [3:0]  op = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] res;
  logic [15:0] res_hi;
  logic [4:0]  flags;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  seq_alu #(.WIDTH(16), .OPW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .res_hi    (res_hi),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic [3:0] o);
    exp_t        e;
    int          sx, sy, sh, t;
    logic [31:0] p;
    logic        c, v, ill;
    logic [15:0] r, hi;
    sx = $signed(x);
    sy = $signed(y);
    sh = int'(y[3:0]);
    r = '0; hi = '0; c = 0; v = 0; ill = 0; e.lat = 1;
    case (o)
      4'd0: r = x & y;
      4'd1: r = x | y;
      4'd2: begin t = sx + sy; r = x + y; c = (int'(x) + int'(y)) > 65535; v = (t > 32767) || (t < -32768); end
      4'd3: begin t = sx - sy; r = x - y; c = (x < y); v = (t > 32767) || (t < -32768); end
      4'd4: r = x ^ y;
      4'd5: r = (sx < sy) ? 16'd1 : 16'd0;
      4'd6: begin r = x << sh; c = (sh != 0) ? x[16-sh] : 1'b0; end
      4'd7: begin r = x >> sh; c = (sh != 0) ? x[sh-1] : 1'b0; end
      4'd8: begin t = sx >>> sh; r = t[15:0]; c = (sh != 0) ? x[sh-1] : 1'b0; end
      4'd9: begin p = {16'd0, x} * {16'd0, y}; r = p[15:0]; hi = p[31:16]; v = (hi != 0); e.lat = 17; end
`ifdef SEQ_ALU_DIV_EN
      4'd10: begin
        e.lat = 17;
        if (y == 0) begin r = 16'hFFFF; hi = x; v = 1; end
        else begin r = x / y; hi = x % y; end
      end
`endif
      default: ill = 1;
    endcase
    e.res   = r;
    e.hi    = hi;
    e.flags = {ill, v, c, r[15], (r == 16'd0)};
    return e;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("in_ready_wait", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic [3:0] o, input exp_t e);
    wait_ready();
    a = x; b = y; op = o; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb.push_back(e);
  endtask

  task automatic issue_m(input logic [15:0] x, input logic [15:0] y, input logic [3:0] o);
    issue(x, y, o, model(x, y, o));
  endtask

  task automatic issue_c(input logic [15:0] x, input logic [15:0] y, input logic [3:0] o,
                         input logic [15:0] r, input logic [15:0] h, input logic [4:0] f, input int l);
    exp_t e;
    e.res = r; e.hi = h; e.flags = f; e.lat = l;
    issue(x, y, o, e);
  endtask

  task automatic collect(input string tag);
    exp_t e;
    int   lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    check({tag, "_sb_nonempty"}, {31'd0, sb.size() != 0}, 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_res"}, {16'd0, res}, {16'd0, e.res});
      check({tag, "_res_hi"}, {16'd0, res_hi}, {16'd0, e.hi});
      check({tag, "_flags"}, {27'd0, flags}, {27'd0, e.flags});
      check({tag, "_latency"}, lat, e.lat);
      check({tag, "_in_ready_low"}, {31'd0, in_ready}, 32'd0);
    end
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_drop_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_in_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra, rb;
    logic [3:0]  ro;
    int          seen;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_res", {16'd0, res}, 32'd0);
    check("rst_res_hi", {16'd0, res_hi}, 32'd0);
    check("rst_flags", {27'd0, flags}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic logic/arith ops on the reference operands
    issue_c(16'h006A, 16'h003B, 4'd0, 16'h002A, 16'h0000, 5'b00000, 1); collect("and");  release_out("and");
    issue_c(16'h006A, 16'h003B, 4'd1, 16'h007B, 16'h0000, 5'b00000, 1); collect("or");   release_out("or");
    issue_c(16'h006A, 16'h003B, 4'd2, 16'h00A5, 16'h0000, 5'b00000, 1); collect("add");  release_out("add");
    issue_c(16'h006A, 16'h003B, 4'd3, 16'h002F, 16'h0000, 5'b00000, 1); collect("sub");  release_out("sub");
    issue_c(16'h006A, 16'h003B, 4'd4, 16'h0051, 16'h0000, 5'b00000, 1); collect("xor");  release_out("xor");

    // Overflow / borrow boundaries
    issue_c(16'h7FFF, 16'h0001, 4'd2, 16'h8000, 16'h0000, 5'b01010, 1); collect("add_ovf"); release_out("add_ovf");
    issue_c(16'h0000, 16'h0001, 4'd3, 16'hFFFF, 16'h0000, 5'b00110, 1); collect("sub_brw"); release_out("sub_brw");

    // Shifts, SLT
    issue_c(16'h8001, 16'h0001, 4'd6, 16'h0002, 16'h0000, 5'b00100, 1); collect("shl1");  release_out("shl1");
    issue_c(16'h8003, 16'h0002, 4'd7, 16'h2000, 16'h0000, 5'b00100, 1); collect("shr2");  release_out("shr2");
    issue_c(16'h8002, 16'h0001, 4'd8, 16'hC001, 16'h0000, 5'b00010, 1); collect("sra1");  release_out("sra1");
    issue_c(16'hFFFF, 16'h0001, 4'd5, 16'h0001, 16'h0000, 5'b00000, 1); collect("slt");   release_out("slt");

    // Multiplier
    issue_c(16'h006A, 16'h003B, 4'd9, 16'h186E, 16'h0000, 5'b00000, 17); collect("mul");     release_out("mul");
    issue_c(16'hFFFF, 16'hFFFF, 4'd9, 16'h0001, 16'hFFFE, 5'b01000, 17); collect("mul_max"); release_out("mul_max");

    // Op 10 and op 15
`ifdef SEQ_ALU_DIV_EN
    issue_c(16'h006A, 16'h003B, 4'd10, 16'h0001, 16'h002F, 5'b00000, 17); collect("divu");   release_out("divu");
    issue_c(16'h1234, 16'h0000, 4'd10, 16'hFFFF, 16'h1234, 5'b01010, 17); collect("divu_0"); release_out("divu_0");
`else
    issue_c(16'h006A, 16'h003B, 4'd10, 16'h0000, 16'h0000, 5'b10001, 1); collect("op10_ill"); release_out("op10_ill");
`endif
    issue_c(16'h006A, 16'h003B, 4'd15, 16'h0000, 16'h0000, 5'b10001, 1); collect("op15_ill"); release_out("op15_ill");

    // Back-pressure: result held, new requests ignored
    out_ready = 1'b0;
    issue_c(16'h1234, 16'h0F0F, 4'd2, 16'h2143, 16'h0000, 5'b00000, 1);
    collect("hold");
    a = 16'hFFFF; b = 16'hFFFF; op = 4'd9; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_res", {16'd0, res}, 32'h2143);
      check("hold_flags", {27'd0, flags}, 32'd0);
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    release_out("hold");
    @(posedge clk); #1;
    check("hold_no_ghost", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of a multiply
    issue_c(16'h00FF, 16'h00FF, 4'd9, 16'h0000, 16'h0000, 5'b00000, 17);
    void'(sb.pop_back());
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_res", {16'd0, res}, 32'd0);
    check("midrst_res_hi", {16'd0, res_hi}, 32'd0);
    check("midrst_flags", {27'd0, flags}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("midrst_no_result", seen, 0);
    issue_c(16'h0100, 16'h0023, 4'd2, 16'h0123, 16'h0000, 5'b00000, 1); collect("post_rst_add"); release_out("post_rst_add");

    // Pseudo-random ops against the reference model
    for (int i = 0; i < 16; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      ro = 4'($urandom_range(0, 15));
      issue_m(ra, rb, ro);
      collect("rand");
      release_out("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
